sd_img_responder: RTL and testbench
===================================

SD_IMG_RESPONDER -- requirements
Module: sd_img_responder

Interface
REQ-001 SECTORS, 400, number of 512-byte sectors in the backing image (40 tracks x 10 sectors).
REQ-002 ADDR_W, 18, byte-address width of the backing memory port; must satisfy 2^ADDR_W >= SECTORS*512.
REQ-003 clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 sd_lba  in  32  sector number, sampled when a request is accepted.
REQ-006 sd_rd  in  1  read request, level, held by the initiator until sd_ack is seen.
REQ-007 sd_wr  in  1  write request, level, held by the initiator until sd_ack is seen.
REQ-008 sd_ack  out  1  high from request acceptance until transfer end.
REQ-009 sd_buff_addr  out  9  byte index within the sector.
REQ-010 sd_buff_dout  out  8  read data to the initiator.
REQ-011 sd_buff_wr  out  1  one-cycle strobe qualifying sd_buff_dout/sd_buff_addr.
REQ-012 sd_buff_din  in  8  write data from the initiator, valid one cycle after sd_buff_addr changes.
REQ-013 img_mounted  out  1  one-cycle pulse announcing the image.
REQ-014 img_readonly  out  1  image write-protect flag.
REQ-015 img_size  out  64  constant SECTORS*512.
REQ-016 mem_addr  out  ADDR_W  backing memory byte address, {lba, index}.
REQ-017 mem_rd  out  1  read strobe; mem_dout valid exactly one cycle later.
REQ-018 mem_dout  in  8  backing memory read data.
REQ-019 mem_wr  out  1  write strobe, one cycle.
REQ-020 mem_din  out  8  backing memory write data.

Function
REQ-021 States SHALL be IDLE, READ_A, READ_B, WRITE_A, WRITE_B, DONE.
REQ-022 In IDLE, sd_rd or sd_wr high SHALL latch sd_lba, clear the index, and assert sd_ack on the next edge; sd_rd SHALL win if both are high.
REQ-023 READ_A SHALL drive mem_addr = lba*512+index and pulse mem_rd; READ_B SHALL present mem_dout on sd_buff_dout with sd_buff_addr = index and pulse sd_buff_wr -- 2 cycles/byte, 1024 cycles/sector.
REQ-024 WRITE_A SHALL drive sd_buff_addr = index; WRITE_B SHALL sample sd_buff_din into mem_din and pulse mem_wr at the same address.
REQ-025 The index SHALL increment after each B state; after index 511 the FSM SHALL enter DONE with no wrap to 0 being transferred.
REQ-026 DONE SHALL deassert sd_ack and return to IDLE only once sd_rd and sd_wr are both low; a request still high SHALL NOT be re-accepted.
REQ-027 For sd_lba >= SECTORS, reads SHALL return 8'hE5 for all 512 bytes without mem_rd, and writes SHALL complete the handshake with no mem_wr.
REQ-028 sd_lba changes while sd_ack is high SHALL be ignored.
REQ-029 img_mounted SHALL pulse exactly once, on the second cycle after reset deasserts; img_size SHALL be constant.

Reset
REQ-030 Reset SHALL force IDLE and drive sd_ack, sd_buff_wr, mem_rd, mem_wr and img_mounted to 0, sd_buff_addr, sd_buff_dout and index to 0, with effect immediate even mid-transfer; no partial byte SHALL be written after reset asserts.

Configuration
REQ-031 With SD_IMG_WRITE_EN defined, writes SHALL update memory per REQ-024 and img_readonly SHALL be 0.
REQ-032 Without SD_IMG_WRITE_EN, img_readonly SHALL be 1, write requests SHALL still run the full 1024-cycle handshake, and mem_wr SHALL stay 0.

Structure
REQ-033 Package sd_img_pkg SHALL hold the state enum, SECTOR_BYTES = 512 and FILL_BYTE = 8'hE5.
REQ-034 The module SHALL be one flat block; backing memory (BRAM/ROM) stays outside.

Verification
REQ-035 Read lba=3 with memory preloaded at byte i = i[7:0]^8'h3C: ack one cycle after sd_rd, 512 sd_buff_wr pulses at addresses 0..511 with matching data, then ack low.
REQ-036 Write lba=7 with the initiator supplying din = index[7:0] (write enabled): 512 mem_wr at addresses 3584..4095 with matching data; read-back equals the written data.
REQ-037 Read lba=400: 512 bytes of 8'hE5, mem_rd never asserted.
REQ-038 sd_rd and sd_wr high together, lba=1: a read is performed and mem_wr stays 0.
REQ-039 Reset asserted at byte 100 of a write: sd_ack and mem_wr go 0 immediately; a following read succeeds normally.
REQ-040 Build without SD_IMG_WRITE_EN: img_readonly=1; a write to lba=2 acks for 1024 cycles with zero mem_wr pulses.

Source files
------------

// File: rtl/sd_img_pkg.sv
// sd_img_pkg: shared state encoding and constants for the SD image responder
package sd_img_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ_A,
        READ_B,
        WRITE_A,
        WRITE_B,
        DONE
    } state_t;

    localparam int SECTOR_BYTES = 512;
    localparam logic [7:0] FILL_BYTE = 8'hE5;

    // True on the final byte index of a sector
    function automatic logic is_last(input logic [8:0] idx);
        return idx == 9'(SECTOR_BYTES - 1);
    endfunction

endpackage

// File: rtl/sd_img_responder_if.sv
// sd_img_responder_if: sector request, sector buffer, image status and backing-memory signals
interface sd_img_responder_if #(
    parameter int ADDR_W = 18
);
    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack;
    logic [8:0]        sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic              sd_buff_wr;
    logic [7:0]        sd_buff_din;
    logic              img_mounted;
    logic              img_readonly;
    logic [63:0]       img_size;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_dout;
    logic              mem_wr;
    logic [7:0]        mem_din;

    // Initiator plus backing memory side
    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_dout,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               img_mounted, img_readonly, img_size, mem_addr, mem_rd, mem_wr, mem_din
    );

    // Responder side
    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_dout,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               img_mounted, img_readonly, img_size, mem_addr, mem_rd, mem_wr, mem_din
    );
endinterface

// File: rtl/sd_img_responder.sv
// sd_img_responder: serves 512-byte sectors of a fixed disk image from external byte memory.
// Define SD_IMG_WRITE_EN to let writes reach memory; otherwise the image is read-only.
module sd_img_responder
    import sd_img_pkg::*;
#(
    parameter int SECTORS = 400,
    parameter int ADDR_W  = 18
) (
    input logic          clk_sys,
    input logic          reset,
    sd_img_responder_if.slave bus
);

    localparam int LBA_W = ADDR_W - 9;

`ifdef SD_IMG_WRITE_EN
    localparam logic WE = 1'b1;
`else
    localparam logic WE = 1'b0;
`endif

    state_t            r_state;
    logic [LBA_W-1:0]  r_lba;
    logic              r_oob;
    logic [8:0]        r_idx;
    logic [1:0]        r_boot;
    logic              r_ack;
    logic [8:0]        r_buff_addr;
    logic [7:0]        r_buff_dout;
    logic              r_buff_wr;
    logic              r_mounted;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [7:0]        r_mem_din;

    logic              w_req_oob;
    logic [8:0]        w_idx_nx;

    assign w_req_oob = bus.sd_lba >= 32'(SECTORS);
    assign w_idx_nx  = r_idx + 9'd1;

    assign bus.sd_ack       = r_ack;
    assign bus.sd_buff_addr = r_buff_addr;
    assign bus.sd_buff_dout = r_buff_dout;
    assign bus.sd_buff_wr   = r_buff_wr;
    assign bus.img_mounted  = r_mounted;
    assign bus.img_readonly = !WE;
    assign bus.img_size     = 64'(SECTORS) * 64'(SECTOR_BYTES);
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_rd       = r_mem_rd;
    assign bus.mem_wr       = r_mem_wr;
    assign bus.mem_din      = r_mem_din;

    // Transfer FSM; memory strobes are launched on entry to the A states so read data lands in B
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_lba       <= '0;
            r_oob       <= 1'b0;
            r_idx       <= '0;
            r_boot      <= '0;
            r_ack       <= 1'b0;
            r_buff_addr <= '0;
            r_buff_dout <= '0;
            r_buff_wr   <= 1'b0;
            r_mounted   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_din   <= '0;
        end else begin
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_buff_wr <= 1'b0;
            r_mounted <= r_boot == 2'd1;
            if (r_boot != 2'd3) r_boot <= r_boot + 2'd1;
            case (r_state)
                IDLE: begin
                    if (bus.sd_rd || bus.sd_wr) begin
                        r_lba <= bus.sd_lba[LBA_W-1:0];
                        r_oob <= w_req_oob;
                        r_idx <= '0;
                        r_ack <= 1'b1;
                        if (bus.sd_rd) begin
                            r_mem_addr <= {bus.sd_lba[LBA_W-1:0], 9'd0};
                            r_mem_rd   <= !w_req_oob;
                            r_state    <= READ_A;
                        end else begin
                            r_buff_addr <= '0;
                            r_state     <= WRITE_A;
                        end
                    end
                end
                READ_A: r_state <= READ_B;
                READ_B: begin
                    r_buff_dout <= r_oob ? FILL_BYTE : bus.mem_dout;
                    r_buff_addr <= r_idx;
                    r_buff_wr   <= 1'b1;
                    if (is_last(r_idx)) begin
                        r_ack   <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_idx      <= w_idx_nx;
                        r_mem_addr <= {r_lba, w_idx_nx};
                        r_mem_rd   <= !r_oob;
                        r_state    <= READ_A;
                    end
                end
                WRITE_A: r_state <= WRITE_B;
                WRITE_B: begin
                    r_mem_din  <= bus.sd_buff_din;
                    r_mem_addr <= {r_lba, r_idx};
                    r_mem_wr   <= WE && !r_oob;
                    if (is_last(r_idx)) begin
                        r_ack   <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_idx       <= w_idx_nx;
                        r_buff_addr <= w_idx_nx;
                        r_state     <= WRITE_A;
                    end
                end
                DONE: if (!bus.sd_rd && !bus.sd_wr) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_img_responder.sv
// tb_sd_img_responder: randomized sector transfers checked against an image model
module tb_sd_img_responder;
    import sd_img_pkg::*;

    localparam int SECTORS = 400;
    localparam int ADDR_W  = 18;
    localparam int DIRTY   = 9;
`ifdef SD_IMG_WRITE_EN
    localparam bit WE = 1'b1;
`else
    localparam bit WE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sd_img_responder_if #(.ADDR_W(ADDR_W)) ifc();
    sd_img_responder #(.SECTORS(SECTORS), .ADDR_W(ADDR_W)) dut (
        .clk_sys(clk),
        .reset(reset),
        .bus(ifc)
    );

    logic [7:0] mem   [2**ADDR_W];
    logic [7:0] model [2**ADDR_W];
    logic [7:0] wbuf  [512];

    int n_cmp = 0;
    int n_bad = 0;
    int n_ack, n_rd, n_mnt = 0;
    logic [8:0]        bw_a[$];
    logic [7:0]        bw_d[$];
    logic [ADDR_W-1:0] mw_a[$];
    logic [7:0]        mw_d[$];

    // Backing memory with one-cycle read latency, and an initiator returning din one cycle after addr
    always @(posedge clk) begin
        if (ifc.mem_rd) ifc.mem_dout <= mem[ifc.mem_addr];
        if (ifc.mem_wr) mem[ifc.mem_addr] <= ifc.mem_din;
        ifc.sd_buff_din <= wbuf[ifc.sd_buff_addr];
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (ifc.sd_buff_wr) begin bw_a.push_back(ifc.sd_buff_addr); bw_d.push_back(ifc.sd_buff_dout); end
            if (ifc.mem_wr) begin mw_a.push_back(ifc.mem_addr); mw_d.push_back(ifc.mem_din); end
            if (ifc.mem_rd) n_rd++;
            if (ifc.sd_ack) n_ack++;
            if (ifc.img_mounted) n_mnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int lba, input int i);
        return lba >= SECTORS ? FILL_BYTE : model[lba * 512 + i];
    endfunction

    task automatic mount_seq(input string tag);
        @(posedge clk); #1 check({tag, " mounted_c1"}, ifc.img_mounted, 0);
        @(posedge clk); #1 check({tag, " mounted_c2"}, ifc.img_mounted, 1);
        @(posedge clk); #1 check({tag, " mounted_c3"}, ifc.img_mounted, 0);
    endtask

    task automatic xfer(input string tag, input bit rd, input bit wr, input int lba);
        int bad, mbad, c;
        bit in_r, is_wr;
        in_r  = lba < SECTORS;
        is_wr = !rd && wr;
        bw_a.delete(); bw_d.delete(); mw_a.delete(); mw_d.delete();
        n_ack = 0;
        n_rd  = 0;
        @(negedge clk);
        ifc.sd_lba = lba;
        ifc.sd_rd  = rd;
        ifc.sd_wr  = wr;
        @(negedge clk);
        check({tag, " ack_rise"}, ifc.sd_ack, 1);
        ifc.sd_lba = $urandom;
        c = 0;
        while (ifc.sd_ack && c < 3000) begin @(negedge clk); c++; end
        check({tag, " ack_fall"}, ifc.sd_ack, 0);
        repeat (5) @(negedge clk);
        ifc.sd_rd = 1'b0;
        ifc.sd_wr = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, " ack_cycles"}, n_ack, 1024);
        check({tag, " buff_wr_count"}, bw_a.size(), rd ? 512 : 0);
        check({tag, " mem_rd_count"}, n_rd, (rd && in_r) ? 512 : 0);
        check({tag, " mem_wr_count"}, mw_a.size(), (is_wr && WE && in_r) ? 512 : 0);
        bad = 0;
        foreach (bw_a[k]) if (bw_a[k] !== 9'(k) || bw_d[k] !== exp_byte(lba, k)) bad++;
        check({tag, " read_bytes_bad"}, bad, 0);
        mbad = 0;
        foreach (mw_a[k]) if (mw_a[k] !== ADDR_W'(lba * 512 + k) || mw_d[k] !== wbuf[k]) mbad++;
        check({tag, " write_bytes_bad"}, mbad, 0);
        if (is_wr && WE && in_r) for (int k = 0; k < 512; k++) model[lba * 512 + k] = wbuf[k];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lba, c;
        bit rd;
        ifc.sd_lba = '0;
        ifc.sd_rd  = 1'b0;
        ifc.sd_wr  = 1'b0;
        for (int i = 0; i < 2**ADDR_W; i++) begin
            mem[i]   = (i < SECTORS * 512) ? (8'(i) ^ 8'h3C) : 8'h00;
            model[i] = mem[i];
        end
        for (int k = 0; k < 512; k++) wbuf[k] = 8'(k);
        #12;
        check("rst ack", ifc.sd_ack, 0);
        check("rst buff_wr", ifc.sd_buff_wr, 0);
        check("rst mem_rd", ifc.mem_rd, 0);
        check("rst mem_wr", ifc.mem_wr, 0);
        check("rst buff_addr", ifc.sd_buff_addr, 0);
        check("img_size", ifc.img_size, 64'd204800);
        check("img_readonly", ifc.img_readonly, !WE);
        @(negedge clk);
        reset = 1'b0;
        mount_seq("boot");

        xfer("rd3", 1, 0, 3);
`ifdef SD_IMG_WRITE_EN
        xfer("wr7", 0, 1, 7);
        xfer("rb7", 1, 0, 7);
`else
        for (int k = 0; k < 512; k++) wbuf[k] = 8'($urandom);
        xfer("wr2_ro", 0, 1, 2);
        xfer("rb2_ro", 1, 0, 2);
`endif
        xfer("rd400", 1, 0, 400);
        xfer("both1", 1, 1, 1);

        for (int n = 0; n < 6; n++) begin
            lba = $urandom_range(0, 460);
            if (lba == DIRTY) lba = 0;
            rd = 1'($urandom);
            for (int k = 0; k < 512; k++) wbuf[k] = 8'($urandom);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            xfer($sformatf("rand%0d_%s%0d", n, rd ? "rd" : "wr", lba), rd, !rd, lba);
        end

        for (int k = 0; k < 512; k++) wbuf[k] = 8'($urandom);
        @(negedge clk);
        ifc.sd_lba = DIRTY;
        ifc.sd_wr  = 1'b1;
        c = 0;
        do begin @(posedge clk); #1; c++; end while (ifc.sd_buff_addr != 9'd100 && c < 2000);
        check("midrst reached_byte100", ifc.sd_buff_addr, 100);
        reset = 1'b1;
        #1;
        check("midrst ack", ifc.sd_ack, 0);
        check("midrst mem_wr", ifc.mem_wr, 0);
        check("midrst buff_addr", ifc.sd_buff_addr, 0);
        ifc.sd_wr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mount_seq("rerst");
        xfer("post_rst_rd5", 1, 0, 5);
        check("mounted_pulses", n_mnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
